// File: rtl/app_stream_pkg.sv
// Shared types for the application word stream decoder:
// field kinds, parser states and the task tag constant.
package app_stream_pkg;

   localparam int unsigned TAG_TASK = 1;

   typedef enum logic [3:0] {
      K_DSIZE, K_TCNT, K_MAP, K_TAG, K_GRAPH,
      K_TEXT, K_DATA, K_BSS, K_ENTRY, K_BIN
   } kind_t;

   typedef enum logic [3:0] {
      S_DSIZE, S_TCNT, S_MAP, S_TAG, S_GRAPH,
      S_TEXT, S_DATA, S_BSS, S_ENTRY, S_BIN
   } state_t;

   function automatic kind_t state_kind(state_t s);
      kind_t k;
      unique case (s)
         S_DSIZE: k = K_DSIZE;
         S_TCNT:  k = K_TCNT;
         S_MAP:   k = K_MAP;
         S_TAG:   k = K_TAG;
         S_GRAPH: k = K_GRAPH;
         S_TEXT:  k = K_TEXT;
         S_DATA:  k = K_DATA;
         S_BSS:   k = K_BSS;
         S_ENTRY: k = K_ENTRY;
         S_BIN:   k = K_BIN;
         default: k = K_DSIZE;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/stream_out_reg.sv
// One-entry valid/ready output register; the producer only loads
// it when it is empty or being drained in the same cycle.
module stream_out_reg #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/app_stream_decoder.sv
// Application word stream parser: tags each word with its field
// kind and task index and forwards it through a one-entry register.
module app_stream_decoder
   import app_stream_pkg::*;
#(
   parameter int FLIT_SIZE = 32,
   parameter int MAX_TASKS = 32,
   parameter int TASK_W    = $clog2(MAX_TASKS)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_i,
   output logic                 credit_o,
   input  logic [FLIT_SIZE-1:0] data_i,
   input  logic                 eoa_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [FLIT_SIZE-1:0] out_data_o,
   output logic [3:0]           out_kind_o,
   output logic [TASK_W-1:0]    out_task_o,
   output logic                 out_eot_o,
   output logic                 app_done_o,
   output logic                 done_o,
   output logic                 err_o
);

   localparam int PW = FLIT_SIZE + 4 + TASK_W + 2;
   localparam logic [FLIT_SIZE-1:0] ONE = FLIT_SIZE'(1);

   state_t               state_q, state_d;
   logic [FLIT_SIZE-1:0] dsize_q, dsize_d;
   logic [FLIT_SIZE-1:0] tcnt_q, tcnt_d;
   logic [FLIT_SIZE-1:0] cnt_q, cnt_d;
   logic [FLIT_SIZE-1:0] task_q, task_d;
   logic [FLIT_SIZE-1:0] sum_q, sum_d;
   logic                 err_q, err_d;

   logic                 xfer;
   logic                 end_task;
   logic                 last_task;
   logic [FLIT_SIZE-1:0] binw;
   kind_t                kind;
   logic [TASK_W-1:0]    tag_task;
   logic                 eot;
   logic                 appd;
   logic                 app_q;
   logic [PW-1:0]        pay_d, pay_q;

   assign credit_o = rst_ni
                   && !(eoa_i && state_q == S_DSIZE)
                   && (!out_valid_o || out_ready_i);
   assign xfer      = rx_i && credit_o;
   assign last_task = (task_q + ONE) >= tcnt_q;
   assign binw      = sum_q >> 2;

   always_comb begin
      state_d  = state_q;
      dsize_d  = dsize_q;
      tcnt_d   = tcnt_q;
      cnt_d    = cnt_q;
      task_d   = task_q;
      sum_d    = sum_q;
      err_d    = err_q;
      end_task = 1'b0;
      eot      = 1'b0;
      appd     = 1'b0;
      kind     = state_kind(state_q);
      tag_task = task_q[TASK_W-1:0];

      // Stream ended before the application was complete.
      if (eoa_i && state_q != S_DSIZE)
         err_d = 1'b1;

      if (xfer) begin
         unique case (state_q)
            S_DSIZE: begin
               tag_task = '0;
               dsize_d  = data_i;
               state_d  = S_TCNT;
            end
            S_TCNT: begin
               tag_task = '0;
               tcnt_d   = data_i;
               task_d   = '0;
               cnt_d    = '0;
               if (data_i > FLIT_SIZE'(MAX_TASKS))
                  err_d = 1'b1;
               if (data_i != '0) begin
                  state_d = S_MAP;
               end else if (dsize_q != '0) begin
                  state_d = S_GRAPH;
               end else begin
                  appd    = 1'b1;
                  state_d = S_DSIZE;
               end
            end
            S_MAP: state_d = S_TAG;
            S_TAG: begin
               if (data_i != FLIT_SIZE'(TAG_TASK))
                  err_d = 1'b1;
               if (!last_task) begin
                  task_d  = task_q + ONE;
                  state_d = S_MAP;
               end else begin
                  task_d  = '0;
                  state_d = (dsize_q != '0) ? S_GRAPH : S_TEXT;
               end
            end
            S_GRAPH: begin
               tag_task = '0;
               if (cnt_q == dsize_q - ONE) begin
                  cnt_d = '0;
                  if (tcnt_q == '0) begin
                     appd    = 1'b1;
                     state_d = S_DSIZE;
                  end else begin
                     state_d = S_TEXT;
                  end
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            S_TEXT: begin
               sum_d   = data_i;
               state_d = S_DATA;
            end
            S_DATA: begin
               sum_d   = sum_q + data_i;
               state_d = S_BSS;
            end
            S_BSS: state_d = S_ENTRY;
            S_ENTRY: begin
               if (binw != '0) begin
                  cnt_d   = '0;
                  state_d = S_BIN;
               end else begin
                  end_task = 1'b1;
               end
            end
            S_BIN: begin
               if (cnt_q == binw - ONE) begin
                  cnt_d    = '0;
                  end_task = 1'b1;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            default: state_d = S_DSIZE;
         endcase

         if (end_task) begin
            eot = 1'b1;
            if (last_task) begin
               appd    = 1'b1;
               task_d  = '0;
               state_d = S_DSIZE;
            end else begin
               task_d  = task_q + ONE;
               state_d = S_TEXT;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_DSIZE;
         dsize_q <= '0;
         tcnt_q  <= '0;
         cnt_q   <= '0;
         task_q  <= '0;
         sum_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dsize_q <= dsize_d;
         tcnt_q  <= tcnt_d;
         cnt_q   <= cnt_d;
         task_q  <= task_d;
         sum_q   <= sum_d;
         err_q   <= err_d;
      end
   end

   assign pay_d = {data_i, kind, tag_task, eot, appd};

   stream_out_reg #(
      .W(PW)
   ) u_out (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (xfer),
      .data_i  (pay_d),
      .ready_i (out_ready_i),
      .valid_o (out_valid_o),
      .data_o  (pay_q)
   );

   assign {out_data_o, out_kind_o, out_task_o, out_eot_o, app_q} = pay_q;

   assign app_done_o = out_valid_o && out_ready_i && app_q;
   assign done_o     = rst_ni && eoa_i && state_q == S_DSIZE
                     && !out_valid_o;
   assign err_o      = err_q;

endmodule

// File: tb/tb_app_stream_decoder.sv
// Directed bench for app_stream_decoder: drives hand-built app
// streams and compares every accepted output word with a table.
module tb_app_stream_decoder;
   import app_stream_pkg::*;

   localparam int FS = 32;
   localparam int TW = 5;

   typedef struct packed {
      logic [FS-1:0] d;
      logic [3:0]    k;
      logic [TW-1:0] t;
      logic          e;
      logic          a;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rx;
   logic          credit;
   logic [FS-1:0] din;
   logic          eoa;
   logic          out_valid;
   logic          out_ready;
   logic [FS-1:0] out_data;
   logic [3:0]    out_kind;
   logic [TW-1:0] out_task;
   logic          out_eot;
   logic          app_done;
   logic          done;
   logic          err;
   logic          tog;

   int   checks = 0;
   int   errors = 0;
   ent_t got_q[$];
   ent_t exp_q[$];
   ent_t mon_e;

   app_stream_decoder #(.FLIT_SIZE(FS), .MAX_TASKS(32)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .rx_i        (rx),
      .credit_o    (credit),
      .data_i      (din),
      .eoa_i       (eoa),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_kind_o  (out_kind),
      .out_task_o  (out_task),
      .out_eot_o   (out_eot),
      .app_done_o  (app_done),
      .done_o      (done),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         mon_e.d = out_data;
         mon_e.k = out_kind;
         mon_e.t = out_task;
         mon_e.e = out_eot;
         mon_e.a = app_done;
         got_q.push_back(mon_e);
      end
      if (rst_n && out_valid && !out_ready)
         chk("credit_full", {63'd0, credit}, 64'd0);
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (tog) out_ready = !out_ready;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send(logic [FS-1:0] w);
      bit ok = 1'b0;
      rx  = 1'b1;
      din = w;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (credit) ok = 1'b1;
      end
      if (ok) begin
         @(posedge clk);
         #1;
      end else begin
         chk("send_timeout", 64'd1, 64'd0);
      end
      rx = 1'b0;
   endtask

   task automatic put(logic [FS-1:0] w, kind_t k, int t, bit e, bit a);
      ent_t x;
      x.d = w;
      x.k = k;
      x.t = TW'(t);
      x.e = e;
      x.a = a;
      exp_q.push_back(x);
      send(w);
   endtask

   task automatic app1(logic [FS-1:0] tagv, int lo, int hi);
      logic [FS-1:0] wv [13];
      kind_t         kv [13];
      wv = '{32'd2, 32'd1, 32'd5, tagv, 32'd7, 32'd8, 32'd8,
             32'd4, 32'd0, 32'h100, 32'ha, 32'hb, 32'hc};
      kv = '{K_DSIZE, K_TCNT, K_MAP, K_TAG, K_GRAPH, K_GRAPH,
             K_TEXT, K_DATA, K_BSS, K_ENTRY, K_BIN, K_BIN, K_BIN};
      for (int i = lo; i < hi; i++)
         put(wv[i], kv[i], 0, i == 12, i == 12);
   endtask

   task automatic drain_cmp(string name);
      int n;
      for (int i = 0; i < 40 && out_valid; i++)
         @(negedge clk);
      @(negedge clk);
      chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_w%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(string name);
      rst_n     = 1'b0;
      rx        = 1'b0;
      eoa       = 1'b0;
      tog       = 1'b0;
      out_ready = 1'b1;
      din       = '0;
      #1;
      chk({name, "_valid"}, {63'd0, out_valid}, 64'd0);
      chk({name, "_credit"}, {63'd0, credit}, 64'd0);
      chk({name, "_err"}, {63'd0, err}, 64'd0);
      chk({name, "_done"}, {63'd0, done}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk({name, "_credit_up"}, {63'd0, credit}, 64'd1);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      do_reset("rst0");

      app1(32'd1, 0, 13);
      drain_cmp("t1");
      chk("t1_err", {63'd0, err}, 64'd0);

      tog = 1'b1;
      app1(32'd1, 0, 13);
      drain_cmp("t2");
      tog = 1'b0;
      out_ready = 1'b1;

      do_reset("rst3");
      put(32'd0, K_DSIZE, 0, 0, 0);
      put(32'd2, K_TCNT, 0, 0, 0);
      put(32'd5, K_MAP, 0, 0, 0);
      put(32'd1, K_TAG, 0, 0, 0);
      put(32'd6, K_MAP, 1, 0, 0);
      put(32'd1, K_TAG, 1, 0, 0);
      put(32'd0, K_TEXT, 0, 0, 0);
      put(32'd0, K_DATA, 0, 0, 0);
      put(32'd0, K_BSS, 0, 0, 0);
      put(32'h40, K_ENTRY, 0, 1, 0);
      put(32'd4, K_TEXT, 1, 0, 0);
      put(32'd4, K_DATA, 1, 0, 0);
      put(32'd0, K_BSS, 1, 0, 0);
      put(32'h80, K_ENTRY, 1, 0, 0);
      put(32'hd, K_BIN, 1, 0, 0);
      put(32'he, K_BIN, 1, 1, 1);
      drain_cmp("t3");
      chk("t3_err", {63'd0, err}, 64'd0);

      do_reset("rst4");
      app1(32'd3, 0, 4);
      chk("t4_tag_err", {63'd0, err}, 64'd1);
      app1(32'd3, 4, 13);
      drain_cmp("t4");
      chk("t4_err_sticky", {63'd0, err}, 64'd1);

      do_reset("rst5");
      app1(32'd1, 0, 11);
      eoa = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_trunc_err", {63'd0, err}, 64'd1);
      chk("t5_trunc_done", {63'd0, done}, 64'd0);

      do_reset("rst5b");
      app1(32'd1, 0, 13);
      eoa = 1'b1;
      @(negedge clk);
      chk("t5_done_busy", {63'd0, done}, 64'd0);
      drain_cmp("t5b");
      chk("t5_done_idle", {63'd0, done}, 64'd1);
      chk("t5_eoa_credit", {63'd0, credit}, 64'd0);
      chk("t5_clean_err", {63'd0, err}, 64'd0);

      do_reset("rst6");
      app1(32'd1, 0, 5);
      out_ready = 1'b0;
      #2;
      chk("t6_held", {63'd0, out_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_valid", {63'd0, out_valid}, 64'd0);
      chk("t6_data", 64'(out_data), 64'd0);
      chk("t6_credit", {63'd0, credit}, 64'd0);
      chk("t6_appdone", {63'd0, app_done}, 64'd0);
      do_reset("rst6b");
      app1(32'd1, 0, 13);
      drain_cmp("t6");
      chk("t6_err", {63'd0, err}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
